sample_sequencer: RTL and testbench
===================================

SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

Interface
REQ-001 SHALL have parameter SIGFIG, default 24, bits in position and color words.
REQ-002 SHALL have parameter RADIX, default 10, fraction bits; one pixel = 1<<RADIX.
REQ-003 SHALL have parameters VERTS = 3, AXIS = 3 and COLORS = 3 (vertices, axes per vertex, color channels).
REQ-004 SHALL have port clk, input, 1, the single clock; all state SHALL be in this domain.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port tri_R13S, input, signed [SIGFIG-1:0] x [VERTS][AXIS], incoming triangle.
REQ-007 SHALL have port color_R13U, input, unsigned [SIGFIG-1:0] x [COLORS], triangle color.
REQ-008 SHALL have port box_R13S, input, signed [SIGFIG-1:0] x [2][2]: [0] = lower-left (x,y), [1] = upper-right (x,y), already snapped to the sample grid.
REQ-009 SHALL have port validTri_R13H, input, 1, triangle/box valid.
REQ-010 SHALL have port subSample_RnnnnU, input, 4, one-hot sample step.
REQ-011 SHALL have port stall_R14H, input, 1, downstream backpressure.
REQ-012 SHALL have port halt_RnnnnH, output, 1, upstream not-ready.
REQ-013 SHALL have port tri_R14S, output, signed [SIGFIG-1:0] x [VERTS][AXIS], latched triangle.
REQ-014 SHALL have port color_R14U, output, unsigned [SIGFIG-1:0] x [COLORS], latched color.
REQ-015 SHALL have port sample_R14S, output, signed [SIGFIG-1:0] x [2], current sample (x,y).
REQ-016 SHALL have port validSamp_R14H, output, 1, sample valid for the sample-test stage.

Function
REQ-017 SHALL implement a 2-state FSM: WAIT and TEST.
REQ-018 SHALL drive halt_RnnnnH combinationally high exactly when state = TEST.
REQ-019 SHALL, in WAIT with validTri_R13H=1 and a non-degenerate box, latch tri, color, box and step, set sample_R14S = box lower-left and enter TEST; validSamp_R14H SHALL go high on the next cycle (1-cycle latency).
REQ-020 SHALL decode the step: 1000 -> 1<<RADIX, 0100 -> 1<<(RADIX-1), 0010 -> 1<<(RADIX-2), 0001 -> 1<<(RADIX-3); any non-one-hot value -> 1<<RADIX.
REQ-021 SHALL treat a box with ur.x < ll.x or ur.y < ll.y as degenerate: stay in WAIT, emit no samples, halt stays low.
REQ-022 SHALL, in TEST with stall_R14H=1, hold every output and all state unchanged.
REQ-023 SHALL, in TEST with stall_R14H=0, advance in raster order: if x+step <= ur.x then x += step; else if y+step <= ur.y then x = ll.x, y += step; else go to WAIT with validSamp_R14H=0 on the next cycle.
REQ-024 SHALL evaluate the comparisons of REQ-023 at SIGFIG+1 signed bits, so that no wrap-around ever produces an extra sample.
REQ-025 SHALL emit exactly ((ur.x-ll.x)/step+1)*((ur.y-ll.y)/step+1) valid samples per triangle, one per unstalled cycle, with no gaps.
REQ-026 SHALL ignore validTri_R13H while in TEST; it SHALL NOT accept a new triangle in the cycle it leaves TEST, so at least one WAIT cycle separates triangles.
REQ-027 SHALL keep tri_R14S and color_R14U constant for the whole TEST period of a triangle.

Reset
REQ-028 SHALL, on rst=1 at any time, including mid-TEST, immediately force state = WAIT, validSamp_R14H=0, halt_RnnnnH=0 and clear all latched registers to 0.
REQ-029 SHALL accept its first triangle on the first clock edge after rst deasserts.

Verification
REQ-030 SHALL cover: box (0,0)-(1024,1024), subSample 1000, accepted at cycle N -> samples (0,0),(1024,0),(0,1024),(1024,1024) valid at N+1..N+4; validSamp and halt low at N+5.
REQ-031 SHALL cover: box (0,0)-(512,0), subSample 0100 -> samples (0,0),(512,0), then WAIT.
REQ-032 SHALL cover: same as REQ-030 with stall_R14H high for 3 cycles while (1024,0) is shown -> (1024,0) is held 4 cycles, sequence otherwise unchanged, halt high throughout.
REQ-033 SHALL cover: box (1024,0)-(0,0) with validTri_R13H=1 -> no validSamp, halt stays 0.
REQ-034 SHALL cover: box (-2048,-1024)-(-1024,-1024), subSample 1000 -> samples (-2048,-1024),(-1024,-1024).
REQ-035 SHALL cover: rst asserted mid-TEST -> validSamp and halt go 0 without waiting for a clock; a new triangle is accepted after rst falls.

Source files
------------

// File: rtl/sample_sequencer_if.sv
// rtl/sample_sequencer_if.sv - triangle-in / sample-out signal bundle for the sample sequencer
interface sample_sequencer_if #(
  parameter int SIGFIG = 24,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
);
  logic signed [SIGFIG-1:0] tri_R13S    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R13U  [COLORS];
  logic signed [SIGFIG-1:0] box_R13S    [2][2];
  logic                     validTri_R13H;
  logic        [3:0]        subSample_RnnnnU;
  logic                     stall_R14H;
  logic                     halt_RnnnnH;
  logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_R14U  [COLORS];
  logic signed [SIGFIG-1:0] sample_R14S [2];
  logic                     validSamp_R14H;

  modport master (
    output tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, stall_R14H,
    input  halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );

  modport slave (
    input  tri_R13S, color_R13U, box_R13S, validTri_R13H, subSample_RnnnnU, stall_R14H,
    output halt_RnnnnH, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
  );
endinterface

// File: rtl/sample_sequencer.sv
// rtl/sample_sequencer.sv - walks a triangle's bounding box in raster order, one sample per unstalled cycle
module sample_sequencer #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input logic                clk,
  input logic                rst,
  sample_sequencer_if.slave  bus
);
  typedef enum logic {WAIT, TEST} state_t;

  localparam logic [SIGFIG-1:0] ONE = SIGFIG'(1) << RADIX;

  state_t                   state_q;
  logic                     valid_q;
  logic signed [SIGFIG-1:0] tri_q    [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_q  [COLORS];
  logic signed [SIGFIG-1:0] sample_q [2];
  logic signed [SIGFIG-1:0] ll_x_q;
  logic signed [SIGFIG-1:0] ur_x_q;
  logic signed [SIGFIG-1:0] ur_y_q;
  logic        [SIGFIG-1:0] step_q;

  logic        [SIGFIG-1:0] step_d;
  logic                     degenerate;
  logic signed [SIGFIG:0]   x_adv_d;
  logic signed [SIGFIG:0]   y_adv_d;
  logic signed [SIGFIG:0]   ur_x_ext;
  logic signed [SIGFIG:0]   ur_y_ext;

  always_comb begin
    step_d = ONE;
    case (bus.subSample_RnnnnU)
      4'b1000: step_d = ONE;
      4'b0100: step_d = ONE >> 1;
      4'b0010: step_d = ONE >> 2;
      4'b0001: step_d = ONE >> 3;
      default: step_d = ONE;
    endcase
  end

  assign degenerate = (bus.box_R13S[1][0] < bus.box_R13S[0][0]) ||
                      (bus.box_R13S[1][1] < bus.box_R13S[0][1]);

  // One extra bit so stepping past the top of the coordinate range never wraps back inside the box.
  assign x_adv_d  = {sample_q[0][SIGFIG-1], sample_q[0]} + {1'b0, step_q};
  assign y_adv_d  = {sample_q[1][SIGFIG-1], sample_q[1]} + {1'b0, step_q};
  assign ur_x_ext = {ur_x_q[SIGFIG-1], ur_x_q};
  assign ur_y_ext = {ur_y_q[SIGFIG-1], ur_y_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT;
      valid_q  <= 1'b0;
      tri_q    <= '{default: '0};
      color_q  <= '{default: '0};
      sample_q <= '{default: '0};
      ll_x_q   <= '0;
      ur_x_q   <= '0;
      ur_y_q   <= '0;
      step_q   <= '0;
    end else begin
      case (state_q)
        WAIT: begin
          if (bus.validTri_R13H && !degenerate) begin
            state_q     <= TEST;
            valid_q     <= 1'b1;
            tri_q       <= bus.tri_R13S;
            color_q     <= bus.color_R13U;
            sample_q[0] <= bus.box_R13S[0][0];
            sample_q[1] <= bus.box_R13S[0][1];
            ll_x_q      <= bus.box_R13S[0][0];
            ur_x_q      <= bus.box_R13S[1][0];
            ur_y_q      <= bus.box_R13S[1][1];
            step_q      <= step_d;
          end
        end
        TEST: begin
          if (!bus.stall_R14H) begin
            if (x_adv_d <= ur_x_ext) begin
              sample_q[0] <= x_adv_d[SIGFIG-1:0];
            end else if (y_adv_d <= ur_y_ext) begin
              sample_q[0] <= ll_x_q;
              sample_q[1] <= y_adv_d[SIGFIG-1:0];
            end else begin
              state_q <= WAIT;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= WAIT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.halt_RnnnnH    = (state_q == TEST);
  assign bus.validSamp_R14H = valid_q;
  assign bus.tri_R14S       = tri_q;
  assign bus.color_R14U     = color_q;
  assign bus.sample_R14S    = sample_q;
endmodule

// File: tb/tb_sample_sequencer.sv
// tb/tb_sample_sequencer.sv - directed bench for sample_sequencer with hand-computed sample sequences
module tb_sample_sequencer;
  localparam int SIGFIG = 24;
  localparam int RADIX  = 10;

  logic clk;
  logic rst;
  int   applied;
  int   miscompares;

  sample_sequencer_if #(.SIGFIG(SIGFIG), .VERTS(3), .AXIS(3), .COLORS(3)) bus ();

  sample_sequencer #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(3), .AXIS(3), .COLORS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    applied++;
    assert (got === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      $error("miscompare on %s", tag);
    end
  endtask

  task automatic samp(input string tag, input int v, input int x, input int y);
    chk({tag, ".valid"}, int'(bus.validSamp_R14H), v);
    chk({tag, ".halt"}, int'(bus.halt_RnnnnH), v);
    if (v == 1) begin
      chk({tag, ".x"}, int'(bus.sample_R14S[0]), x);
      chk({tag, ".y"}, int'(bus.sample_R14S[1]), y);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_box(input int llx, input int lly, input int urx, input int ury,
                         input logic [3:0] sub, input logic vld);
    bus.box_R13S[0][0]   = SIGFIG'(llx);
    bus.box_R13S[0][1]   = SIGFIG'(lly);
    bus.box_R13S[1][0]   = SIGFIG'(urx);
    bus.box_R13S[1][1]   = SIGFIG'(ury);
    bus.subSample_RnnnnU = sub;
    bus.validTri_R13H    = vld;
  endtask

  task automatic set_tri(input int base);
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++)
        bus.tri_R13S[v][a] = SIGFIG'(base + v * 3 + a);
    for (int c = 0; c < 3; c++)
      bus.color_R13U[c] = SIGFIG'(base * 2 + c);
  endtask

  initial begin
    applied     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.stall_R14H = 1'b0;
    set_tri(100);
    set_box(0, 0, 1024, 1024, 4'b1000, 1'b0);
    tick();
    tick();
    samp("reset", 0, 0, 0);
    chk("reset.sample_x", int'(bus.sample_R14S[0]), 0);
    chk("reset.tri00", int'(bus.tri_R14S[0][0]), 0);
    chk("reset.color2", int'(bus.color_R14U[2]), 0);

    // 2x2 grid at full pixel step, accepted on the first edge after reset
    rst = 1'b0;
    set_box(0, 0, 1024, 1024, 4'b1000, 1'b1);
    tick();
    bus.validTri_R13H = 1'b0;
    set_tri(500);
    samp("full.s0", 1, 0, 0);
    chk("full.tri21", int'(bus.tri_R14S[2][1]), 107);
    chk("full.color1", int'(bus.color_R14U[1]), 201);
    tick(); samp("full.s1", 1, 1024, 0);
    tick(); samp("full.s2", 1, 0, 1024);
    chk("full.tri_hold", int'(bus.tri_R14S[2][1]), 107);
    tick(); samp("full.s3", 1, 1024, 1024);
    tick(); samp("full.done", 0, 0, 0);

    set_box(0, 0, 512, 0, 4'b0100, 1'b1);
    tick(); bus.validTri_R13H = 1'b0;
    samp("half.s0", 1, 0, 0);
    tick(); samp("half.s1", 1, 512, 0);
    tick(); samp("half.done", 0, 0, 0);

    set_box(0, 0, 128, 0, 4'b0001, 1'b1);
    tick(); bus.validTri_R13H = 1'b0;
    samp("eighth.s0", 1, 0, 0);
    tick(); samp("eighth.s1", 1, 128, 0);
    tick(); samp("eighth.done", 0, 0, 0);

    set_box(0, 0, 1024, 0, 4'b0011, 1'b1);
    tick(); bus.validTri_R13H = 1'b0;
    samp("nonhot.s0", 1, 0, 0);
    tick(); samp("nonhot.s1", 1, 1024, 0);
    tick(); samp("nonhot.done", 0, 0, 0);

    // stall while (1024,0) is shown; validTri kept high to show it is ignored in TEST
    set_box(0, 0, 1024, 1024, 4'b1000, 1'b1);
    tick(); samp("stall.s0", 1, 0, 0);
    set_box(0, 0, 2048, 2048, 4'b1000, 1'b1);
    tick(); samp("stall.s1", 1, 1024, 0);
    bus.stall_R14H = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); samp($sformatf("stall.hold%0d", i), 1, 1024, 0);
    end
    bus.stall_R14H = 1'b0;
    tick(); samp("stall.s2", 1, 0, 1024);
    tick(); samp("stall.s3", 1, 1024, 1024);
    tick(); samp("stall.gap", 0, 0, 0);
    tick(); samp("stall.next", 1, 0, 0);
    bus.validTri_R13H = 1'b0;
    tick(); samp("stall.next1", 1, 1024, 0);

    // asynchronous reset in the middle of TEST
    #2 rst = 1'b1;
    #1 samp("arst.now", 0, 0, 0);
    chk("arst.tri00", int'(bus.tri_R14S[0][0]), 0);
    tick(); samp("arst.held", 0, 0, 0);
    rst = 1'b0;
    set_box(0, 0, 1024, 0, 4'b1000, 1'b1);
    tick(); bus.validTri_R13H = 1'b0;
    samp("arst.accept", 1, 0, 0);
    tick(); samp("arst.s1", 1, 1024, 0);
    tick(); samp("arst.done", 0, 0, 0);

    set_box(1024, 0, 0, 0, 4'b1000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); samp($sformatf("degen%0d", i), 0, 0, 0);
    end
    bus.validTri_R13H = 1'b0;

    set_box(-2048, -1024, -1024, -1024, 4'b1000, 1'b1);
    tick(); bus.validTri_R13H = 1'b0;
    samp("neg.s0", 1, -2048, -1024);
    tick(); samp("neg.s1", 1, -1024, -1024);
    tick(); samp("neg.done", 0, 0, 0);

    // x + step would wrap past the most positive coordinate
    set_box(8387584, 0, 8388607, 0, 4'b1000, 1'b1);
    tick(); bus.validTri_R13H = 1'b0;
    samp("wrap.s0", 1, 8387584, 0);
    tick(); samp("wrap.done", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
